frame_pattern_checker: RTL

//  Receive-side checker for the periodic 1-bit frame pattern produced by the pattern generator (data2/datavalid stream).

---
 rtl/frame_pattern_checker.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/frame_pattern_checker.sv
// Receive-side checker for the periodic 1-bit frame pattern: hunts for pattern phase,
// locks after LOCK_CNT clean periods, counts bit errors and drops lock after LOSE_CNT bad periods.
module frame_pattern_checker #(
    parameter int PERIOD   = 4,
    parameter int HIGH_LEN = 2,
    parameter int LOCK_CNT = 3,
    parameter int LOSE_CNT = 2,
    parameter int ERR_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din,
    input  logic                      din_en,
    input  logic                      err_clr,
    output logic                      locked,
    output logic [1:0]                state,
    output logic [$clog2(PERIOD)-1:0] phase,
    output logic                      frame_tick,
    output logic                      err_pulse,
    output logic [ERR_W-1:0]          err_cnt
);
    localparam int PH_W = $clog2(PERIOD);
    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam int BC_W = $clog2(LOSE_CNT + 1);
    localparam logic [PH_W-1:0] LAST_PH   = PH_W'(PERIOD - 1);
    localparam logic [PH_W-1:0] HIGH_PH   = PH_W'(HIGH_LEN);
    localparam logic [GC_W-1:0] LOCK_LAST = GC_W'(LOCK_CNT - 1);
    localparam logic [BC_W-1:0] LOSE_LAST = BC_W'(LOSE_CNT - 1);

    typedef enum logic [1:0] {
        HUNT  = 2'b00,
        CHECK = 2'b01,
        SYNC  = 2'b10
    } state_t;

    state_t            state_reg,   state_next;
    logic [PH_W-1:0]   phase_reg,   phase_next;
    logic [GC_W-1:0]   good_reg,    good_next;
    logic [BC_W-1:0]   bad_reg,     bad_next;
    logic              pbad_reg,    pbad_next;
    logic              prev_reg,    prev_next;
    logic              tick_reg,    tick_next;
    logic              errp_reg,    errp_next;
    logic [ERR_W-1:0]  err_cnt_reg, err_cnt_next;

    logic              expected;
    logic              mismatch;
    logic              last_ph;
    logic [PH_W-1:0]   phase_inc;

    assign expected  = (phase_reg < HIGH_PH);
    assign mismatch  = din ^ expected;
    assign last_ph   = (phase_reg == LAST_PH);
    assign phase_inc = last_ph ? '0 : phase_reg + PH_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= HUNT;
            phase_reg   <= '0;
            good_reg    <= '0;
            bad_reg     <= '0;
            pbad_reg    <= 1'b0;
            prev_reg    <= 1'b0;
            tick_reg    <= 1'b0;
            errp_reg    <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            good_reg    <= good_next;
            bad_reg     <= bad_next;
            pbad_reg    <= pbad_next;
            prev_reg    <= prev_next;
            tick_reg    <= tick_next;
            errp_reg    <= errp_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        good_next    = good_reg;
        bad_next     = bad_reg;
        pbad_next    = pbad_reg;
        prev_next    = prev_reg;
        tick_next    = 1'b0;
        errp_next    = 1'b0;
        err_cnt_next = err_cnt_reg;

        if (din_en) begin
            prev_next = din;
            case (state_reg)
                HUNT: begin
                    // A rising edge in the stream marks sample 0 of a period.
                    if (din && !prev_reg) begin
                        state_next = CHECK;
                        phase_next = PH_W'(1);
                        good_next  = '0;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        state_next = HUNT;
                        phase_next = '0;
                        good_next  = '0;
                    end else begin
                        phase_next = phase_inc;
                        if (last_ph) begin
                            good_next = good_reg + GC_W'(1);
                            if (good_reg == LOCK_LAST) begin
                                state_next = SYNC;
                                bad_next   = '0;
                                pbad_next  = 1'b0;
                            end
                        end
                    end
                end
                SYNC: begin
                    phase_next = phase_inc;
                    if (mismatch) begin
                        errp_next = 1'b1;
                        if (err_cnt_reg != '1)
                            err_cnt_next = err_cnt_reg + ERR_W'(1);
                    end
                    if (last_ph) begin
                        tick_next = 1'b1;
                        pbad_next = 1'b0;
                        if (pbad_reg || mismatch) begin
                            bad_next = bad_reg + BC_W'(1);
                            if (bad_reg == LOSE_LAST) begin
                                state_next = HUNT;
                                phase_next = '0;
                            end
                        end else begin
                            bad_next = '0;
                        end
                    end else if (mismatch) begin
                        pbad_next = 1'b1;
                    end
                end
                default: begin
                    state_next = HUNT;
                    phase_next = '0;
                end
            endcase
        end

        // Clear wins over a same-cycle increment.
        if (err_clr)
            err_cnt_next = '0;
    end

    assign locked     = (state_reg == SYNC);
    assign state      = state_reg;
    assign phase      = phase_reg;
    assign frame_tick = tick_reg;
    assign err_pulse  = errp_reg;
    assign err_cnt    = err_cnt_reg;

endmodule
